// File: rtl/str_byte_assembler.sv
// Packs a NUL-terminated byte stream into a right-justified, left-truncated string vector
// and presents it with its length and an overflow flag on a valid/ready output.
module str_byte_assembler #(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned LW        = $clog2(MAX_CHARS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAX_CHARS*8-1:0] out_str,
  output logic [LW-1:0]          out_len,
  output logic                   out_ovf
);

  localparam int unsigned SW = MAX_CHARS * 8;

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [SW-1:0]   r_buf, w_buf_nxt;
  logic [LW-1:0]   r_len, w_len_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_live;

  logic            w_accept;
  logic            w_is_nul;
  logic [SW+7:0]   w_cat;
  logic [SW-1:0]   w_shifted;
  logic            w_full;

  assign w_accept  = in_valid && in_ready;
  assign w_is_nul  = (in_data == 8'h00);
  // Oldest character falls off the top when the buffer is already full.
  assign w_cat     = {r_buf, in_data};
  assign w_shifted = w_cat[SW-1:0];
  assign w_full    = (r_len == LW'(MAX_CHARS));

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_ovf_nxt = 1'b0;
          if (w_is_nul) begin
            w_state_nxt = StDone;
            w_buf_nxt   = '0;
            w_len_nxt   = '0;
          end else begin
            w_state_nxt = StCollect;
            w_buf_nxt   = w_shifted;
            w_len_nxt   = LW'(1);
          end
        end
      end
      StCollect: begin
        if (w_accept) begin
          if (w_is_nul) begin
            w_state_nxt = StDone;
          end else begin
            w_buf_nxt = w_shifted;
            if (w_full) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_len_nxt = r_len + LW'(1);
            end
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_nxt = StIdle;
          w_buf_nxt   = '0;
          w_len_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_buf_nxt   = '0;
        w_len_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_buf   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  assign in_ready  = r_live && (r_state != StDone);
  assign out_valid = (r_state == StDone);
  assign out_str   = out_valid ? r_buf : '0;
  assign out_len   = out_valid ? r_len : '0;
  assign out_ovf   = out_valid ? r_ovf : 1'b0;

endmodule

// File: tb/tb_str_byte_assembler.sv
// Drives one byte stream into 16- and 4-character assemblers; a queue holds the expected
// result of each string and is checked when the assemblers hand a string out.
module tb_str_byte_assembler;

  typedef struct packed {
    logic [127:0] s16;
    logic [4:0]   l16;
    logic         o16;
    logic [31:0]  s4;
    logic [2:0]   l4;
    logic         o4;
  } exp_t;

  typedef struct packed {
    logic [159:0] txt;
    logic [4:0]   n;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         out_ready;

  logic         rdy16, v16, o16;
  logic [127:0] s16;
  logic [4:0]   l16;
  logic         rdy4, v4, o4;
  logic [31:0]  s4;
  logic [2:0]   l4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t m_e;
  vec_t vecs[7];

  always #5 clk = ~clk;

  str_byte_assembler #(.MAX_CHARS(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data),
    .out_valid(v16), .out_ready(out_ready), .out_str(s16), .out_len(l16), .out_ovf(o16)
  );

  str_byte_assembler #(.MAX_CHARS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .out_valid(v4), .out_ready(out_ready), .out_str(s4), .out_len(l4), .out_ovf(o4)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_e(input logic [127:0] a16, input int b16, input bit c16,
                                input logic [31:0] a4, input int b4, input bit c4);
    exp_t e;
    e.s16 = a16; e.l16 = 5'(b16); e.o16 = c16;
    e.s4  = a4;  e.l4  = 3'(b4);  e.o4  = c4;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic [159:0] t, input int n, input exp_t e);
    vec_t v;
    v.txt = t; v.n = 5'(n); v.e = e;
    return v;
  endfunction

  // Scoreboard: pop and compare whenever a string is handed out.
  always @(negedge clk) begin
    if (!rst && (v16 || v4) && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got str16=%h expected no output", s16);
      end else begin
        m_e = sb.pop_front();
        chk("valid16", 128'(v16), 128'(1'b1));
        chk("valid4", 128'(v4), 128'(1'b1));
        chk("str16", s16, m_e.s16);
        chk("len16", 128'(l16), 128'(m_e.l16));
        chk("ovf16", 128'(o16), 128'(m_e.o16));
        chk("str4", 128'(s4), 128'(m_e.s4));
        chk("len4", 128'(l4), 128'(m_e.l4));
        chk("ovf4", 128'(o4), 128'(m_e.o4));
      end
    end
  end

  // Called one time unit after a rising edge; returns one time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!rdy16 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", 128'(n < 50), 128'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    sb.push_back(v.e);
    for (int i = 0; i < int'(v.n); i++) send_byte(v.txt[8*(int'(v.n)-1-i) +: 8]);
    send_byte(8'h00);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    vecs[0] = mk_v(160'("A"), 1, mk_e(128'h41, 1, 0, 32'h41, 1, 0));
    vecs[1] = mk_v(160'("hello"), 5, mk_e(128'h68656C6C6F, 5, 0, 32'h656C6C6F, 4, 1));
    vecs[2] = mk_v(160'("Hi"), 2, mk_e(128'h4869, 2, 0, 32'h0000_4869, 2, 0));
    vecs[3] = mk_v(160'("abcd"), 4, mk_e(128'h61626364, 4, 0, 32'h61626364, 4, 0));
    vecs[4] = mk_v(160'(0), 0, mk_e(128'h0, 0, 0, 32'h0, 0, 0));
    vecs[5] = mk_v(160'("ABCDEFGHIJKLMNOPQ"), 17,
                   mk_e(128'h42434445464748494A4B4C4D4E4F5051, 16, 1, 32'h4E4F5051, 4, 1));
    vecs[6] = mk_v(160'("0123456789abcdef"), 16,
                   mk_e(128'h30313233343536373839616263646566, 16, 0, 32'h63646566, 4, 1));

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready16", 128'(rdy16), 128'(1'b0));
    chk("rst_in_ready4", 128'(rdy4), 128'(1'b0));
    chk("rst_out_valid", 128'(v16), 128'(1'b0));
    chk("rst_out_str", s16, 128'h0);
    chk("rst_out_len", 128'(l16), 128'(0));
    chk("rst_out_ovf", 128'(o16), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_first_clk", 128'(rdy16), 128'(1'b0));
    @(posedge clk);
    #1;
    chk("ready_after_first_clk", 128'(rdy16), 128'(1'b1));

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_vec(vecs[i]);
    wait_drain();

    // Back-to-back with the one-cycle input bubble.
    sb.push_back(mk_e(128'h78, 1, 0, 32'h78, 1, 0));
    send_byte(8'h78);
    send_byte(8'h00);
    chk("bubble_ready_low", 128'(rdy16), 128'(1'b0));
    chk("bubble_valid_high", 128'(v16), 128'(1'b1));
    @(posedge clk);
    #1;
    chk("bubble_ready_back", 128'(rdy16), 128'(1'b1));
    chk("bubble_valid_low", 128'(v16), 128'(1'b0));
    sb.push_back(mk_e(128'h79, 1, 0, 32'h79, 1, 0));
    send_byte(8'h79);
    send_byte(8'h00);
    wait_drain();

    // Bytes with the top bit set are ordinary characters.
    sb.push_back(mk_e(128'hFF80, 2, 0, 32'hFF80, 2, 0));
    send_byte(8'hFF);
    send_byte(8'h80);
    send_byte(8'h00);
    wait_drain();

    // Empty string held in DONE while upstream keeps a byte pending.
    out_ready = 1'b0;
    sb.push_back(mk_e(128'h0, 0, 0, 32'h0, 0, 0));
    send_byte(8'h00);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_ready", 128'(rdy16), 128'(1'b0));
      chk("stall_valid", 128'(v16), 128'(1'b1));
      chk("stall_len", 128'(l16), 128'(0));
      chk("stall_str", s16, 128'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", 128'(v16), 128'(1'b0));
    chk("release_ready", 128'(rdy16), 128'(1'b1));
    chk("release_popped", 128'(sb.size()), 128'(0));

    // Reset mid-string discards the partial string.
    send_byte(8'h61);
    send_byte(8'h62);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 128'(rdy16), 128'(1'b0));
    chk("midrst_valid", 128'(v16), 128'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_vec(mk_v(160'("c"), 1, mk_e(128'h63, 1, 0, 32'h63, 1, 0)));
    wait_drain();

    // Reset while a string is pending produces no output for it.
    out_ready = 1'b0;
    send_byte(8'h71);
    send_byte(8'h00);
    chk("pending_valid", 128'(v16), 128'(1'b1));
    rst = 1'b1;
    #1;
    chk("pending_rst_valid", 128'(v16), 128'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("pending_dropped", 128'(v16), 128'(1'b0));
    chk("final_queue", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/str_byte_assembler.md
Name: str_byte_assembler

Overview:
- Receiving end of the byte-stream string path. Accepts ASCII bytes over a valid/ready handshake and packs them into a fixed-width packed string vector.
- Packing follows SystemVerilog string-to-vector semantics: right-justified, zero-padded on the left, and truncated on the left when the string is too long.
- A NUL byte (8'h00) terminates each string. The packed result is then presented on a valid/ready output with its length and an overflow flag.
- Sits between the byte-stream transmitter and any consumer of packed string/tag registers.

Parameters:
- MAX_CHARS, 16: capacity in characters; out_str width is MAX_CHARS*8.
- LW, $clog2(MAX_CHARS+1): width of out_len (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  byte available on in_data.
- in_ready  output  1  assembler can accept a byte.
- in_data  input  8  ASCII byte; 8'h00 = terminator.
- out_valid  output  1  assembled string available.
- out_ready  input  1  consumer accepts string.
- out_str  output  MAX_CHARS*8  packed string; last received char in [7:0].
- out_len  output  LW  number of characters held (0..MAX_CHARS).
- out_ovf  output  1  more than MAX_CHARS chars were received; oldest were dropped.

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready=0 while rst high, then 1 on the first clock after release; out_valid=0; out_str=0; out_len=0; out_ovf=0.
- Byte accept: in_valid && in_ready at a rising edge. in_data is ignored otherwise.
- States: IDLE, COLLECT, DONE.
- IDLE: in_ready=1.
  - Accepted non-NUL byte: buf <= {buf[MAX_CHARS*8-9:0], in_data}, len <= 1, go to COLLECT.
  - Accepted NUL: go to DONE with len=0, buf=0, ovf=0 (empty string).
- COLLECT: in_ready=1.
  - Accepted non-NUL byte: shift-in as above. len <= len+1, saturating at MAX_CHARS.
  - Accepted non-NUL byte while len==MAX_CHARS: byte is still shifted in (oldest char lost) and ovf <= 1.
  - Accepted NUL: go to DONE.
- DONE: in_ready=0, out_valid=1.
  - out_str/out_len/out_ovf are driven from buf/len/ovf and stay stable until the handshake.
  - out_valid && out_ready: buf, len and ovf are cleared and state returns to IDLE. in_ready rises the next cycle (one-cycle input bubble per string).
- Latency: out_valid rises on the clock edge that accepts the NUL (visible in the following cycle).
- out_str, out_len and out_ovf are 0 whenever out_valid=0 (register outputs gated by state).
- Exactly MAX_CHARS characters is not overflow: len=MAX_CHARS, ovf=0.
- Reset asserted mid-COLLECT or mid-DONE discards the partial or pending string. No output is produced for it.
- out_ready is ignored outside DONE. in_valid is ignored in DONE; the upstream must hold its byte.
- Bytes 8'h80–8'hFF are treated as ordinary characters.

Test Plan:
- MAX_CHARS=16; send 8'h41, 8'h00 -> out_valid next cycle; out_str=128'h41; out_len=1; out_ovf=0.
- MAX_CHARS=4; send "hello" (68 65 6C 6C 6F) then 00 -> out_str=32'h656C6C6F ("ello"); out_len=4; out_ovf=1.
- MAX_CHARS=4; send "Hi" then 00 -> out_str=32'h0000_4869; out_len=2. Then send "abcd", 00 -> out_str=32'h61626364; out_len=4; out_ovf=0.
- Send lone 00 -> out_valid=1; out_len=0; out_str=0. Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout. Assert out_ready -> out_valid=0 next cycle, in_ready=1.
- Send "ab", assert rst for 1 cycle mid-string, then send "c", 00 -> out_str low bytes=8'h63 only; out_len=1.
- Back-to-back strings "x",00,"y",00 with out_ready tied high -> two outputs (8'h78 then 8'h79), separated by the one-cycle in_ready bubble.
